// File: rtl/uart_rx_ctl_n.sv
// UART 8N1 receive controller with a built-in 16x oversample baud generator.
// Optional parity stage enabled by defining UART_RX_PARITY_EN (8E1/8O1 via PARITY_ODD).
module uart_rx_ctl_n #(
   parameter int BAUD_RATE  = 115200,
   parameter int CLOCK_RATE = 100_000_000,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       clk_rx,
   input  logic       rst_clk_rx_n,
   input  logic       rxd_i,
   output logic [7:0] rx_data,
   output logic       rx_data_rdy,
   output logic       frm_err,
   output logic       par_err,
   output logic       rx_busy
);

   localparam int DIV_CALC = (CLOCK_RATE + BAUD_RATE * 8) / (BAUD_RATE * 16);
   localparam int DIV      = (DIV_CALC < 1) ? 1 : DIV_CALC;
   localparam int CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_BREAK
   } state_t;

   logic       baud_en;
   logic [1:0] sync_reg;
   logic       rxd_s;

   state_t     state_reg;
   logic [3:0] ov_cnt_reg;
   logic [2:0] bit_cnt_reg;
   logic [7:0] shift_reg;
   logic [7:0] rx_data_reg;
   logic       rdy_reg;
   logic       frm_reg;
   logic       par_reg;
   logic       par_pend_reg;

   // rxd_i is asynchronous to clk_rx; idle-high reset avoids a false start bit.
   always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
      if (!rst_clk_rx_n) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], rxd_i};
      end
   end

   assign rxd_s = sync_reg[1];

   generate
      if (DIV == 1) begin : g_div1
         assign baud_en = 1'b1;
      end else begin : g_divn
         localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
         logic [CNT_W-1:0] baud_cnt_reg;

         always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
            if (!rst_clk_rx_n) begin
               baud_cnt_reg <= '0;
            end else if (baud_cnt_reg == DIV_LAST) begin
               baud_cnt_reg <= '0;
            end else begin
               baud_cnt_reg <= baud_cnt_reg + 1'b1;
            end
         end

         assign baud_en = (baud_cnt_reg == DIV_LAST);
      end
   endgenerate

   always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
      if (!rst_clk_rx_n) begin
         state_reg    <= ST_IDLE;
         ov_cnt_reg   <= 4'd0;
         bit_cnt_reg  <= 3'd0;
         shift_reg    <= 8'h00;
         rx_data_reg  <= 8'h00;
         rdy_reg      <= 1'b0;
         frm_reg      <= 1'b0;
         par_reg      <= 1'b0;
         par_pend_reg <= 1'b0;
      end else begin
         // Strobes default low so each lasts one clk_rx regardless of DIV.
         rdy_reg <= 1'b0;
         frm_reg <= 1'b0;
         par_reg <= 1'b0;
         if (baud_en) begin
            case (state_reg)
               ST_IDLE: begin
                  if (!rxd_s) begin
                     state_reg  <= ST_START;
                     ov_cnt_reg <= 4'd0;
                  end
               end
               ST_START: begin
                  if (ov_cnt_reg == 4'd7) begin
                     if (!rxd_s) begin
                        state_reg    <= ST_DATA;
                        ov_cnt_reg   <= 4'd0;
                        bit_cnt_reg  <= 3'd0;
                        par_pend_reg <= 1'b0;
                     end else begin
                        state_reg <= ST_IDLE;
                     end
                  end else begin
                     ov_cnt_reg <= ov_cnt_reg + 4'd1;
                  end
               end
               ST_DATA: begin
                  ov_cnt_reg <= ov_cnt_reg + 4'd1;
                  if (ov_cnt_reg == 4'd15) begin
                     shift_reg   <= {rxd_s, shift_reg[7:1]};
                     bit_cnt_reg <= bit_cnt_reg + 3'd1;
                     if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_reg <= ST_PARITY;
`else
                        state_reg <= ST_STOP;
`endif
                     end
                  end
               end
`ifdef UART_RX_PARITY_EN
               ST_PARITY: begin
                  ov_cnt_reg <= ov_cnt_reg + 4'd1;
                  if (ov_cnt_reg == 4'd15) begin
                     par_pend_reg <= ((^shift_reg) ^ rxd_s) != PARITY_ODD;
                     state_reg    <= ST_STOP;
                  end
               end
`endif
               ST_STOP: begin
                  ov_cnt_reg <= ov_cnt_reg + 4'd1;
                  if (ov_cnt_reg == 4'd15) begin
                     if (rxd_s) begin
                        state_reg <= ST_IDLE;
                        if (par_pend_reg) begin
                           par_reg <= 1'b1;
                        end else begin
                           rx_data_reg <= shift_reg;
                           rdy_reg     <= 1'b1;
                        end
                     end else begin
                        // Framing error wins over any pending parity error.
                        frm_reg   <= 1'b1;
                        state_reg <= ST_BREAK;
                     end
                  end
               end
               ST_BREAK: begin
                  if (rxd_s) begin
                     state_reg <= ST_IDLE;
                  end
               end
               default: begin
                  state_reg <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign rx_data     = rx_data_reg;
   assign rx_data_rdy = rdy_reg;
   assign frm_err     = frm_reg;
   assign rx_busy     = (state_reg != ST_IDLE);

`ifdef UART_RX_PARITY_EN
   assign par_err = par_reg;
`else
   logic unused_parity_cfg;
   assign unused_parity_cfg = PARITY_ODD ^ par_reg ^ par_pend_reg;
   assign par_err = 1'b0;
`endif

endmodule
